miniproc_exec_unit: RTL and testbench

MINIPROC_EXEC_UNIT -- requirements
Module: miniproc_exec_unit

---
 rtl/miniproc_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_miniproc_exec_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/miniproc_exec_unit.sv
// miniproc_exec_unit: sequences one R-type instruction through
// IDLE -> READ -> EXEC -> WRITE -> DONE. It registers the ALU operands at
// the end of EXEC and computes RESULT combinationally from those registers.
// Optional feature macro: MINIPROC_MUL_EN. When it is defined, function
// 6'h2c multiplies. When it is undefined, no multiplier is built and 6'h2c
// yields 0.
module miniproc_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            OPCODE,
    input  logic [5:0]            FUNCT,
    input  logic [4:0]            SHAMT,
    input  logic [DATA_WIDTH-1:0] DATA_R1,
    input  logic [DATA_WIDTH-1:0] DATA_R2,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [5:0]            ALU_CODE,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [DATA_WIDTH-1:0] RESULT
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
`ifdef MINIPROC_MUL_EN
    localparam logic [5:0] FN_MUL = 6'h2c;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [5:0]            code_q, code_d;
    // Remembers whether the captured instruction was R-type, so that the
    // WRITE cycle knows whether to pulse RF_WRITE.
    logic                  wr_en_q, wr_en_d;

    // State and operand registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            code_q  <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            code_q  <= code_d;
            wr_en_q <= wr_en_d;
        end
    end

    // Next state; the inputs are captured only while leaving EXEC
    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        code_d  = code_q;
        wr_en_d = wr_en_q;
        case (state_q)
            ST_IDLE:  state_d = ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_WRITE;
                if (OPCODE == 6'h00) begin
                    op1_d   = DATA_R1;
                    code_d  = FUNCT;
                    wr_en_d = 1'b1;
                    if (FUNCT == FN_SLL || FUNCT == FN_SRL) begin
                        op2_d = {{(DATA_WIDTH-5){1'b0}}, SHAMT};
                    end else begin
                        op2_d = DATA_R2;
                    end
                end else begin
                    // Non-R-type: clear the operands so RESULT reads 0 and no write occurs
                    op1_d   = '0;
                    op2_d   = '0;
                    code_d  = '0;
                    wr_en_d = 1'b0;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Register-file strobes decoded from the current state
    always_comb begin
        RF_READ  = 1'b0;
        RF_WRITE = 1'b0;
        case (state_q)
            ST_READ:  RF_READ  = 1'b1;
            ST_EXEC:  RF_READ  = 1'b1;
            ST_WRITE: RF_WRITE = wr_en_q;
            default: begin
                RF_READ  = 1'b0;
                RF_WRITE = 1'b0;
            end
        endcase
    end

    assign ALU_OP1  = op1_q;
    assign ALU_OP2  = op2_q;
    assign ALU_CODE = code_q;

    // Bitwise logic terms, built one slice per bit
    logic [DATA_WIDTH-1:0] and_bits;
    logic [DATA_WIDTH-1:0] or_bits;
    logic [DATA_WIDTH-1:0] nor_bits;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bitwise
            assign and_bits[gi] = op1_q[gi] & op2_q[gi];
            assign or_bits[gi]  = op1_q[gi] | op2_q[gi];
            assign nor_bits[gi] = ~(op1_q[gi] | op2_q[gi]);
        end
    endgenerate

    // A shift by the full width or more must yield zero, not wrap modulo 32
    logic shift_oob;
    assign shift_oob = (op2_q >= DATA_WIDTH);

    // Combinational ALU driven only by the registered operands
    always_comb begin
        RESULT = '0;
        case (code_q)
            FN_ADD: RESULT = op1_q + op2_q;
            FN_SUB: RESULT = op1_q - op2_q;
`ifdef MINIPROC_MUL_EN
            FN_MUL: RESULT = op1_q * op2_q;
`endif
            FN_SLL: RESULT = shift_oob ? '0 : (op1_q << op2_q[SH_W-1:0]);
            FN_SRL: RESULT = shift_oob ? '0 : (op1_q >> op2_q[SH_W-1:0]);
            FN_AND: RESULT = and_bits;
            FN_OR:  RESULT = or_bits;
            FN_NOR: RESULT = nor_bits;
            FN_SLT: RESULT = (op1_q < op2_q) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : '0;
            default: RESULT = '0;
        endcase
    end

endmodule

// File: tb/tb_miniproc_exec_unit.sv
// Testbench for miniproc_exec_unit. It uses directed vectors and random
// transactions, and checks them against an arithmetic reference model.
// The expectation for 6'h2c follows the MINIPROC_MUL_EN macro.
module tb_miniproc_exec_unit;

    logic        CLK;
    logic        RST;
    logic [5:0]  OPCODE;
    logic [5:0]  FUNCT;
    logic [4:0]  SHAMT;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic [31:0] ALU_OP1;
    logic [31:0] ALU_OP2;
    logic [5:0]  ALU_CODE;
    logic        RF_READ;
    logic        RF_WRITE;
    logic [31:0] RESULT;

    int checks   = 0;
    int failures = 0;

    miniproc_exec_unit #(.DATA_WIDTH(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .OPCODE   (OPCODE),
        .FUNCT    (FUNCT),
        .SHAMT    (SHAMT),
        .DATA_R1  (DATA_R1),
        .DATA_R2  (DATA_R2),
        .ALU_OP1  (ALU_OP1),
        .ALU_OP2  (ALU_OP2),
        .ALU_CODE (ALU_CODE),
        .RF_READ  (RF_READ),
        .RF_WRITE (RF_WRITE),
        .RESULT   (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: the result an instruction should produce, from the ISA rules
    function automatic logic [31:0] model_result(input logic [5:0] opc, input logic [5:0] fn,
                                                 input logic [4:0] sh, input logic [31:0] r1,
                                                 input logic [31:0] r2);
        logic [31:0] b;
        longint unsigned prod;
        if (opc != 6'h00) return 32'd0;
        b = (fn == 6'h01 || fn == 6'h02) ? {27'd0, sh} : r2;
        case (fn)
            6'h20: return r1 + b;
            6'h22: return r1 - b;
            6'h2c: begin
`ifdef MINIPROC_MUL_EN
                prod = longint'(r1) * longint'(b);
                return prod[31:0];
`else
                prod = 0;
                return prod[31:0];
`endif
            end
            6'h01: return (b >= 32) ? 32'd0 : r1 << b;
            6'h02: return (b >= 32) ? 32'd0 : r1 >> b;
            6'h24: return r1 & b;
            6'h25: return r1 | b;
            6'h27: return ~(r1 | b);
            6'h2a: return (r1 < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if ({ALU_OP1, ALU_OP2, ALU_CODE, RF_READ, RF_WRITE, RESULT} !== '0) begin
            failures++;
            $display("FAIL %s reset_outputs got op1=%h op2=%h code=%h rd=%b wr=%b res=%h exp all zero",
                     tag, ALU_OP1, ALU_OP2, ALU_CODE, RF_READ, RF_WRITE, RESULT);
        end
    endtask

    // Runs one instruction. The caller must already be in reset, just after
    // a reset edge. Correct inputs are driven only during the EXEC cycle
    // (cycle 3); with scramble set, random values are driven in every other
    // cycle.
    task automatic run_txn(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [31:0] r1, input logic [31:0] r2, input bit scramble,
                           input string tag);
        logic [31:0] exp_res, exp_op1, exp_op2;
        logic [5:0]  exp_code;
        int          pulses;
        exp_res  = model_result(opc, fn, sh, r1, r2);
        exp_op1  = (opc == 0) ? r1 : 32'd0;
        exp_op2  = (opc != 0) ? 32'd0 : ((fn == 6'h01 || fn == 6'h02) ? {27'd0, sh} : r2);
        exp_code = (opc == 0) ? fn : 6'd0;
        pulses   = 0;
        check_zero_outputs(tag);
        RST = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 3 || !scramble) begin
                OPCODE = opc; FUNCT = fn; SHAMT = sh; DATA_R1 = r1; DATA_R2 = r2;
            end else begin
                OPCODE = 6'($urandom); FUNCT = 6'($urandom); SHAMT = 5'($urandom);
                DATA_R1 = $urandom; DATA_R2 = $urandom;
            end
            @(negedge CLK);
            if (RF_WRITE) pulses++;
            checks++;
            if (RF_READ !== (c == 2 || c == 3)) begin
                failures++;
                $display("FAIL %s rf_read cyc=%0d got=%b exp=%b", tag, c, RF_READ, (c == 2 || c == 3));
            end
            checks++;
            if (RF_WRITE !== (c == 4 && opc == 0)) begin
                failures++;
                $display("FAIL %s rf_write cyc=%0d got=%b exp=%b", tag, c, RF_WRITE, (c == 4 && opc == 0));
            end
            if (c >= 4) begin
                checks++;
                if (RESULT !== exp_res || ALU_OP1 !== exp_op1 || ALU_OP2 !== exp_op2 || ALU_CODE !== exp_code) begin
                    failures++;
                    $display("FAIL %s alu cyc=%0d got res=%h op1=%h op2=%h code=%h exp res=%h op1=%h op2=%h code=%h",
                             tag, c, RESULT, ALU_OP1, ALU_OP2, ALU_CODE, exp_res, exp_op1, exp_op2, exp_code);
                end
            end else begin
                checks++;
                if (RESULT !== 32'd0 || ALU_CODE !== 6'd0) begin
                    failures++;
                    $display("FAIL %s early_result cyc=%0d got res=%h code=%h exp 0", tag, c, RESULT, ALU_CODE);
                end
            end
            @(posedge CLK);
            #1;
        end
        checks++;
        if (pulses != ((opc == 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s write_pulses got=%0d exp=%0d", tag, pulses, (opc == 0) ? 1 : 0);
        end
        $display("txn %s opc=%h fn=%h sh=%0d r1=%h r2=%h exp_res=%h got_res=%h", tag, opc, fn, sh, r1, r2, exp_res, RESULT);
    endtask

    task automatic test_reset();
        OPCODE = 0; FUNCT = 0; SHAMT = 0; DATA_R1 = 0; DATA_R2 = 0;
        apply_reset();
        apply_reset();
        check_zero_outputs("reset");
    endtask

    task automatic test_directed();
        apply_reset(); run_txn(6'h00, 6'h20, 5'd0, 32'd18, 32'd3, 1'b0, "add18_3");
        apply_reset(); run_txn(6'h00, 6'h2c, 5'd0, 32'd12, 32'd7, 1'b0, "mul12_7");
        apply_reset(); run_txn(6'h00, 6'h01, 5'd2, 32'd9, 32'd5, 1'b0, "sll9_2");
        apply_reset(); run_txn(6'h00, 6'h02, 5'd1, 32'd84, 32'd0, 1'b0, "srl84_1");
        apply_reset(); run_txn(6'h00, 6'h27, 5'd0, 32'd36, 32'd42, 1'b0, "nor36_42");
        apply_reset(); run_txn(6'h00, 6'h2a, 5'd0, 32'hFFFFFFD1, 32'd8, 1'b0, "slt_big");
        apply_reset(); run_txn(6'h00, 6'h2a, 5'd0, 32'd4, 32'd14, 1'b0, "slt4_14");
        apply_reset(); run_txn(6'h00, 6'h22, 5'd0, 32'd15, 32'd5, 1'b0, "sub15_5");
        apply_reset(); run_txn(6'h08, 6'h20, 5'd0, 32'd15, 32'd5, 1'b0, "opc08");
        apply_reset(); run_txn(6'h00, 6'h20, 5'd0, 32'hFFFFFFFF, 32'd2, 1'b0, "add_wrap");
        apply_reset(); run_txn(6'h00, 6'h22, 5'd0, 32'd0, 32'd1, 1'b0, "sub_wrap");
        apply_reset(); run_txn(6'h00, 6'h3f, 5'd0, 32'd7, 32'd9, 1'b0, "unknown_fn");
    endtask

    task automatic test_random();
        logic [5:0] fn_list [10];
        logic [5:0] opc, fn;
        fn_list = '{6'h20, 6'h22, 6'h2c, 6'h01, 6'h02, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00};
        for (int i = 0; i < 40; i++) begin
            opc = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
            fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 9)];
            apply_reset();
            run_txn(opc, fn, 5'($urandom), $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                    1'b1, $sformatf("rand%0d", i));
        end
    endtask

    // Aborts a transaction with reset at the given cycle (3 = EXEC, 4 = WRITE),
    // then checks that a clean full sequence follows.
    task automatic test_reset_mid(input int stop_cycle, input string tag);
        apply_reset();
        RST = 1'b0;
        OPCODE = 6'h00; FUNCT = 6'h25; SHAMT = 5'd0; DATA_R1 = 32'h00F0; DATA_R2 = 32'h0F00;
        for (int c = 1; c < stop_cycle; c++) begin
            @(posedge CLK);
            #1;
        end
        checks++;
        if ((stop_cycle == 3 && RF_READ !== 1'b1) || (stop_cycle == 4 && RF_WRITE !== 1'b1)) begin
            failures++;
            $display("FAIL %s pre_abort got rd=%b wr=%b exp strobe=1", tag, RF_READ, RF_WRITE);
        end
        apply_reset();
        run_txn(6'h00, 6'h20, 5'd0, 32'd100, 32'd23, 1'b0, tag);
    endtask

    initial begin
        RST = 1'b1;
        test_reset();
        test_directed();
        apply_reset(); run_txn(6'h00, 6'h24, 5'd0, 32'hDEADBEEF, 32'h0000FFFF, 1'b1, "sampling");
        test_reset_mid(3, "rst_exec");
        test_reset_mid(4, "rst_write");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
